// File: rtl/bram_table_loader_pkg.sv
// Shared types and default sizing for the BRAM table loader.
// State encoding plus the default geometry of one S-box table.
package bram_table_loader_pkg;

  localparam int ADDR_W_D   = 10;
  localparam int DATA_W_D   = 8;
  localparam int DEPTH_D    = 1024;
  localparam int READ_LAT_D = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/bram_rd_valid_pipe.sv
// Read-valid shift register that tracks outstanding BRAM reads.
// Ports: clk, rst_n, clr (sync clear), push, tap (data valid now), empty.
module bram_rd_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  output logic tap,
  output logic empty
);

  logic [LAT-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (clr) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // push is the read address on the bus right now, so it
  // must also count as outstanding.
  assign tap   = vld[LAT-1];
  assign empty = ~(|vld) & ~push;

endmodule

// File: rtl/bram_table_loader.sv
// Loads a byte stream into a dual-port BRAM two entries at a time,
// reads it back and compares XOR checksums of write vs readback.
// Ports: clk, rst_n, start, abort, in_data/in_valid/in_ready,
// bram_en/we/addra/addrb/dia/dib/doa/dob, busy, done, pass.
module bram_table_loader
  import bram_table_loader_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int READ_LAT = READ_LAT_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic [DATA_W-1:0] bram_dia,
  output logic [DATA_W-1:0] bram_dib,
  input  logic [DATA_W-1:0] bram_doa,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              busy,
  output logic              done,
  output logic              pass
);

  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] LAST = PAIR_W'(DEPTH / 2 - 1);

  state_t            state;
  logic [PAIR_W-1:0] pair;
  logic [PAIR_W-1:0] rptr;
  logic              phase;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] wr_csum;
  logic [DATA_W-1:0] rd_csum;
  logic              rd_issue;
  logic              active;
  logic              go;
  logic              vld_clr;
  logic              vld_tap;
  logic              vld_empty;

  assign active  = state inside {S_LOAD, S_VERIFY, S_DRAIN};
  assign go      = (state == S_IDLE) && start && !abort;
  assign vld_clr = (active && abort) || go;

  bram_rd_valid_pipe #(
    .LAT (READ_LAT)
  ) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (vld_clr),
    .push  (rd_issue),
    .tap   (vld_tap),
    .empty (vld_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pair       <= '0;
      rptr       <= '0;
      phase      <= 1'b0;
      hold       <= '0;
      wr_csum    <= '0;
      rd_csum    <= '0;
      rd_issue   <= 1'b0;
      in_ready   <= 1'b0;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addra <= '0;
      bram_addrb <= '0;
      bram_dia   <= '0;
      bram_dib   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (vld_tap) begin
        rd_csum <= rd_csum ^ bram_doa ^ bram_dob;
      end
      if (active && abort) begin
        state    <= S_IDLE;
        rd_issue <= 1'b0;
        in_ready <= 1'b0;
        bram_en  <= 1'b0;
        bram_we  <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (go) begin
              state    <= S_LOAD;
              pair     <= '0;
              rptr     <= '0;
              phase    <= 1'b0;
              wr_csum  <= '0;
              rd_csum  <= '0;
              pass     <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
          S_LOAD: begin
            bram_en <= 1'b0;
            bram_we <= 1'b0;
            if (in_valid && in_ready) begin
              wr_csum <= wr_csum ^ in_data;
              if (!phase) begin
                hold  <= in_data;
                phase <= 1'b1;
              end else begin
                phase      <= 1'b0;
                bram_en    <= 1'b1;
                bram_we    <= 1'b1;
                bram_addra <= {pair, 1'b0};
                bram_addrb <= {pair, 1'b1};
                bram_dia   <= hold;
                bram_dib   <= in_data;
                if (pair == LAST) begin
                  state    <= S_VERIFY;
                  in_ready <= 1'b0;
                  rptr     <= '0;
                end else begin
                  pair <= pair + 1'b1;
                end
              end
            end
          end
          S_VERIFY: begin
            bram_en    <= 1'b1;
            bram_we    <= 1'b0;
            bram_addra <= {rptr, 1'b0};
            bram_addrb <= {rptr, 1'b1};
            rd_issue   <= 1'b1;
            if (rptr == LAST) begin
              state <= S_DRAIN;
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
          S_DRAIN: begin
            rd_issue <= 1'b0;
            // empty implies no sample this cycle, so rd_csum is final
            if (vld_empty) begin
              state   <= S_DONE;
              bram_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (wr_csum == rd_csum);
            end
          end
          S_DONE: begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_table_loader.sv
// Directed/randomized bench for bram_table_loader with a
// behavioural dual-port BRAM (two-cycle read latency).
module tb_bram_table_loader;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1024;
  localparam int RL = 2;
  localparam int MIN_CYC = DEPTH + 1 + DEPTH / 2 + RL + 1;
  localparam logic [AW-1:0] FLIP_A = 10'h1F3;
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addra;
  logic [AW-1:0] bram_addrb;
  logic [DW-1:0] bram_dia;
  logic [DW-1:0] bram_dib;
  logic [DW-1:0] bram_doa;
  logic [DW-1:0] bram_dob;
  logic          busy;
  logic          done;
  logic          pass;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] s1a, s1b;
  logic [DW-1:0] stream [DEPTH];
  bit            flip_pending = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            t_start = 0;
  int            wpair = 0;

  bram_table_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addra (bram_addra),
    .bram_addrb (bram_addrb),
    .bram_dia   (bram_dia),
    .bram_dib   (bram_dib),
    .bram_doa   (bram_doa),
    .bram_dob   (bram_dob),
    .busy       (busy),
    .done       (done),
    .pass       (pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port BRAM, write-first not needed: reads never overlap writes.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addra] <= bram_dia;
        mem[bram_addrb] <= bram_dib;
        if (flip_pending && bram_addra == LAST_A)
          mem[FLIP_A] <= mem[FLIP_A] ^ 8'h01;
      end
      s1a      <= mem[bram_addra];
      s1b      <= mem[bram_addrb];
      bram_doa <= s1a;
      bram_dob <= s1b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write must be the next pair of the stream, in order.
  always @(negedge clk) begin
    if (!busy) begin
      wpair = 0;
    end else if (bram_we) begin
      chk("wr_pair",
          {bram_en, bram_addra, bram_addrb, bram_dia, bram_dib},
          {1'b1, AW'(2 * wpair), AW'(2 * wpair + 1),
           stream[2 * wpair], stream[2 * wpair + 1]});
      wpair = wpair + 1;
    end
  end

  function automatic logic [63:0] outs();
    return {in_ready, bram_en, bram_we, bram_addra, bram_addrb,
            bram_dia, bram_dib, busy, done, pass};
  endfunction

  task automatic fill(input bit ramp);
    for (int i = 0; i < DEPTH; i++)
      stream[i] = ramp ? DW'(i) : DW'($urandom);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_start = cyc;
    chk({tag, "_start"}, {busy, in_ready, pass, done}, 4'b1100);
  endtask

  // gap: 0 none, 3 every third cycle idle, -1 random idles.
  task automatic feed(input int gap, input int abort_at,
                      input int restart_at);
    int idx = 0;
    int g = 0;
    bit acc;
    while (idx < DEPTH && g < 8000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        abort = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outs", {busy, bram_we, bram_en, in_ready, pass, done},
            6'b0);
        g = 0;
        repeat (20) begin
          @(negedge clk);
          if (done || busy) g++;
        end
        chk("abort_quiet", g, 0);
        return;
      end
      if (gap == 3) in_valid = (g % 3) != 2;
      else if (gap < 0) in_valid = $urandom_range(0, 3) != 0;
      else in_valid = 1'b1;
      in_data = stream[idx];
      start = (g == restart_at);
      acc = in_valid && in_ready;
      @(negedge clk);
      g++;
      if (acc) idx++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("feed_bound", idx, DEPTH);
  endtask

  task automatic wait_done(input string tag, input bit flip,
                           input bit start_in_done);
    int n = 0;
    int extra = 0;
    int mism = 0;
    bit seen = 1'b0;
    logic [DW-1:0] xs, xm, e;
    while (!seen && n < 5000) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    xs = '0;
    xm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = stream[i] ^ ((flip && AW'(i) == FLIP_A) ? 8'h01 : 8'h00);
      if (mem[i] !== e) mism++;
      xs = xs ^ stream[i];
      xm = xm ^ e;
    end
    chk({tag, "_contents"}, mism, 0);
    chk({tag, "_pass"}, {busy, pass}, {1'b0, xs == xm});
    chk({tag, "_latency"}, (cyc - t_start) >= MIN_CYC, 1'b1);
    if (start_in_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_after"}, {busy, in_ready, bram_en, done}, 4'b0);
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({tag, "_single_done"}, extra, 0);
  endtask

  initial begin
    #3;
    chk("reset_outs", outs(), 64'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp stream, continuous valid.
    fill(1'b1);
    do_start("ramp");
    feed(0, -1, -1);
    wait_done("ramp", 1'b0, 1'b0);

    // Same stream, every third cycle idle.
    do_start("gap3");
    feed(3, -1, -1);
    wait_done("gap3", 1'b0, 1'b0);

    // Random stream, one bit corrupted after the last write.
    fill(1'b0);
    flip_pending = 1'b1;
    do_start("flip");
    feed(-1, -1, -1);
    wait_done("flip", 1'b1, 1'b0);
    flip_pending = 1'b0;

    // Abort after 300 accepts, then a full load with stray starts.
    fill(1'b0);
    do_start("abort");
    feed(0, 300, -1);
    fill(1'b0);
    do_start("reload");
    feed(-1, -1, 400);
    wait_done("reload", 1'b0, 1'b1);

    // Asynchronous reset during readback at r=100.
    fill(1'b0);
    do_start("rst");
    feed(0, -1, -1);
    begin
      int n = 0;
      while (!(bram_en && !bram_we && bram_addra == 10'd200) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("rst_reach_r100", n < 2000, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs(), 64'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_idle", {bram_en, busy, in_ready}, 3'b0);

    fill(1'b0);
    do_start("post_rst");
    feed(-1, -1, -1);
    wait_done("post_rst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
